// File: rtl/long_prim_stim_checker.sv
// Exhaustive stimulus/response checker for the serial XOR/NOT primitive chain.
// Each vector is held for S = max(SETTLE, DEPTH) cycles, then compared once against a serial golden model.
module long_prim_stim_checker #(
  parameter int IO_PAIRS = 2,
  parameter int DEPTH    = 32,
  parameter int SETTLE   = DEPTH + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [2*IO_PAIRS-1:0] dut_in,
  input  logic [2*IO_PAIRS-1:0] dut_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [7:0]            err_count,
  output logic                  err_valid,
  output logic [2*IO_PAIRS-1:0] first_err_vec,
  output logic [2*IO_PAIRS-1:0] first_err_got
);

  // state     | meaning
  // ST_IDLE   | after reset, waiting for start
  // ST_SETTLE | current vector held on dut_in while the model steps through the stages
  // ST_CHECK  | single-cycle compare of dut_out against the model
  // ST_DONE   | results frozen; start launches a fresh run

  localparam int W  = 2 * IO_PAIRS;
  localparam int S  = (SETTLE > DEPTH) ? SETTLE : DEPTH;
  localparam int CW = $clog2(S + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_C  = CW'(S - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK, ST_DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    vec;
  logic [W-1:0]    model;
  logic [CW-1:0]   cnt;
  logic            launch;
  logic            last_vec;
  logic            mismatch;

  function automatic logic [W-1:0] stage(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int j = 0; j < IO_PAIRS; j++) begin
      r[2*j]   = ~v[2*j];
      r[2*j+1] = v[2*j] ^ v[2*j+1];
    end
    return r;
  endfunction

  assign launch   = ((state == ST_IDLE) || (state == ST_DONE)) && start;
  assign last_vec = (vec == {W{1'b1}});
  assign mismatch = (dut_out != model);
  assign dut_in   = vec;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_SETTLE;
      ST_SETTLE:        if (cnt == LAST_C) state_nxt = ST_CHECK;
      ST_CHECK:         state_nxt = last_vec ? ST_DONE : ST_SETTLE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_SETTLE) || (state == ST_CHECK);
    done = (state == ST_DONE);
    pass = (state == ST_DONE) && (err_count == 8'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec           <= '0;
      model         <= '0;
      cnt           <= '0;
      err_count     <= '0;
      err_valid     <= 1'b0;
      first_err_vec <= '0;
      first_err_got <= '0;
    end else if (launch) begin
      vec           <= '0;
      model         <= '0;
      cnt           <= '0;
      err_count     <= '0;
      err_valid     <= 1'b0;
      first_err_vec <= '0;
      first_err_got <= '0;
    end else if (state == ST_SETTLE) begin
      // Model stops after DEPTH stages even when the hold window is longer.
      if (cnt < DEPTH_C) model <= stage(model);
      cnt <= cnt + CW'(1);
    end else if (state == ST_CHECK) begin
      if (mismatch) begin
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        if (!err_valid) begin
          err_valid     <= 1'b1;
          first_err_vec <= vec;
          first_err_got <= dut_out;
        end
      end
      if (!last_vec) begin
        vec   <= vec + W'(1);
        model <= vec + W'(1);
        cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_long_prim_stim_checker.sv
// Scoreboard bench for long_prim_stim_checker: three instances with different parameters,
// bench-side chain models (ideal, stuck-bit, inverted) and expected run results pushed at launch.
module tb_long_prim_stim_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         at;
    bit         pass;
    int         errc;
    bit         errv;
    logic [9:0] fvec;
    logic [9:0] fgot;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  // Instance 0: defaults (IO_PAIRS=2, DEPTH=32 -> identity chain)
  logic       start0 = 1'b0;
  logic [3:0] in0, out0, fv0, fg0;
  logic       busy0, done0, pass0, ev0;
  logic [7:0] ec0;
  int         fault0 = 0;

  always_comb begin
    case (fault0)
      0:       out0 = in0;
      1:       out0 = in0 & 4'b1110;
      default: out0 = ~in0;
    endcase
  end

  long_prim_stim_checker u0 (
    .clk(clk), .rst(rst), .start(start0), .dut_in(in0), .dut_out(out0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(ec0), .err_valid(ev0),
    .first_err_vec(fv0), .first_err_got(fg0)
  );

  // Instance 1: DEPTH=3, SETTLE=3; chain given by a hand-derived lookup table
  logic       start1 = 1'b0;
  logic [3:0] in1, out1, fv1, fg1;
  logic       busy1, done1, pass1, ev1;
  logic [7:0] ec1;
  logic [3:0] tbl1 [16] = '{4'hF, 4'hC, 4'hD, 4'hE, 4'h3, 4'h0, 4'h1, 4'h2,
                             4'h7, 4'h4, 4'h5, 4'h6, 4'hB, 4'h8, 4'h9, 4'hA};
  assign out1 = tbl1[in1];

  long_prim_stim_checker #(.IO_PAIRS(2), .DEPTH(3), .SETTLE(3)) u1 (
    .clk(clk), .rst(rst), .start(start1), .dut_in(in1), .dut_out(out1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(ec1), .err_valid(ev1),
    .first_err_vec(fv1), .first_err_got(fg1)
  );

  // Instance 2: IO_PAIRS=5, DEPTH=4 (identity), SETTLE=2 < DEPTH so S=4; output inverted
  logic       start2 = 1'b0;
  logic [9:0] in2, out2, fv2, fg2;
  logic       busy2, done2, pass2, ev2;
  logic [7:0] ec2;
  assign out2 = ~in2;

  long_prim_stim_checker #(.IO_PAIRS(5), .DEPTH(4), .SETTLE(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .dut_in(in2), .dut_out(out2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(ec2), .err_valid(ev2),
    .first_err_vec(fv2), .first_err_got(fg2)
  );

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void cmp_res(string tag, exp_t e, int at, bit p, int ec, bit ev,
                                  logic [9:0] fv, logic [9:0] fg);
    chk({tag, "_done_cycle"}, at, e.at);
    chk({tag, "_pass"}, p, e.pass);
    chk({tag, "_err_count"}, ec, e.errc);
    chk({tag, "_err_valid"}, ev, e.errv);
    chk({tag, "_first_err_vec"}, fv, e.fvec);
    chk({tag, "_first_err_got"}, fg, e.fgot);
  endfunction

  function automatic void unexpected(string tag);
    checks++;
    failures++;
    $display("FAIL %s_unexpected_done got=1 want=0 at cycle %0d", tag, cyc);
  endfunction

  // Monitors: pop one expected result whenever done rises
  bit dprev0 = 0, dprev1 = 0, dprev2 = 0, bprev0 = 0;
  int last0 = 0;

  always @(negedge clk) begin
    if (done0 && !dprev0) begin
      if (q0.size() == 0) unexpected("dut0");
      else cmp_res("dut0", q0.pop_front(), cyc, pass0, ec0, ev0, {6'b0, fv0}, {6'b0, fg0});
    end
    if (busy0 && (int'(in0) != last0))
      chk("dut0_walk", in0, bprev0 ? last0 + 1 : 0);
    dprev0 = done0;
    bprev0 = busy0;
    last0  = int'(in0);
  end

  always @(negedge clk) begin
    if (done1 && !dprev1) begin
      if (q1.size() == 0) unexpected("dut1");
      else cmp_res("dut1", q1.pop_front(), cyc, pass1, ec1, ev1, {6'b0, fv1}, {6'b0, fg1});
    end
    dprev1 = done1;
  end

  always @(negedge clk) begin
    if (done2 && !dprev2) begin
      if (q2.size() == 0) unexpected("dut2");
      else cmp_res("dut2", q2.pop_front(), cyc, pass2, ec2, ev2, fv2, fg2);
    end
    dprev2 = done2;
  end

  function automatic int qsize(int which);
    case (which)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic set_start(int which, logic v);
    case (which)
      0:       start0 = v;
      1:       start1 = v;
      default: start2 = v;
    endcase
  endtask

  // One-cycle start pulse; c returns the cycle index of the sampling edge.
  task automatic go(int which, output int c);
    @(negedge clk);
    set_start(which, 1'b1);
    @(posedge clk);
    #1 c = cyc;
    @(negedge clk);
    set_start(which, 1'b0);
  endtask

  task automatic wait_q(int which, int n, int limit);
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      if (qsize(which) <= n) return;
    end
    checks++;
    failures++;
    $display("FAIL dut%0d_timeout got=%0d pending want=%0d", which, qsize(which), n);
    case (which)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endtask

  initial begin
    int c;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dut_in", in0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_pass", pass0, 0);
    chk("rst_err_count", ec0, 0);
    chk("rst_err_valid", ev0, 0);
    chk("rst_first_vec", fv0, 0);
    chk("rst_first_got", fg0, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_done1", done1, 0);
    chk("rst_busy2", busy2, 0);
    chk("rst_dut_in2", in2, 0);
    rst = 1'b0;

    // Ideal run with stray start pulses at cycles 10 and 300
    go(0, c);
    q0.push_back(exp_t'{c + 560, 1'b1, 0, 1'b0, 10'd0, 10'd0});
    while (cyc < c + 9) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("repulse10_busy", busy0, 1);
    while (cyc < c + 299) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("repulse300_busy", busy0, 1);
    wait_q(0, 0, 600);

    // Output bit0 stuck at 0: odd vectors fail
    fault0 = 1;
    go(0, c);
    q0.push_back(exp_t'{c + 560, 1'b0, 8, 1'b1, 10'd1, 10'd0});
    wait_q(0, 0, 700);

    // Start from DONE clears the previous errors
    fault0 = 0;
    go(0, c);
    chk("restart_done", done0, 0);
    chk("restart_err_count", ec0, 0);
    chk("restart_err_valid", ev0, 0);
    chk("restart_first_vec", fv0, 0);
    chk("restart_busy", busy0, 1);
    q0.push_back(exp_t'{c + 560, 1'b1, 0, 1'b0, 10'd0, 10'd0});
    wait_q(0, 0, 700);

    // Reset at cycle 200 of a faulty run
    fault0 = 1;
    go(0, c);
    while (cyc < c + 199) @(negedge clk);
    chk("pre_rst_err_count", ec0, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy0, 0);
    chk("abort_err_count", ec0, 0);
    chk("abort_err_valid", ev0, 0);
    chk("abort_first_vec", fv0, 0);
    chk("abort_dut_in", in0, 0);
    chk("abort_done", done0, 0);
    fault0 = 0;
    go(0, c);
    q0.push_back(exp_t'{c + 560, 1'b1, 0, 1'b0, 10'd0, 10'd0});
    wait_q(0, 0, 700);

    // start held high: a second run begins the cycle after DONE is entered
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1 c = cyc;
    q0.push_back(exp_t'{c + 560, 1'b1, 0, 1'b0, 10'd0, 10'd0});
    q0.push_back(exp_t'{c + 1121, 1'b1, 0, 1'b0, 10'd0, 10'd0});
    wait_q(0, 1, 700);
    @(negedge clk);
    start0 = 1'b0;
    wait_q(0, 0, 700);

    // DEPTH=3 instance against the hand table
    go(1, c);
    q1.push_back(exp_t'{c + 64, 1'b1, 0, 1'b0, 10'd0, 10'd0});
    wait_q(1, 0, 200);

    // Wide instance, every vector mismatches -> saturation
    go(2, c);
    q2.push_back(exp_t'{c + 5120, 1'b0, 255, 1'b1, 10'd0, 10'h3FF});
    wait_q(2, 0, 6000);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
